// File: rtl/haar_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// haar_pkg : shared types and width helpers for the Haar cascade blocks
// Revision : 1.0
// ---------------------------------------------------------------------------
package haar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STAGE_RD  = 3'd1,
        ST_STAGE_LAT = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_EVAL      = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    // The accumulator must hold 2**ADDR_WIDTH worst-case haar values.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned aw);
        return dw + aw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/haar_stage_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// haar_stage_controller_if : scanner handshake plus stage/feature ROM bus
// Revision : 1.0
// ---------------------------------------------------------------------------
interface haar_stage_controller_if
    import haar_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int STAGE_AW   = 4,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
);
    logic                  i_start;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_face;
    logic [STAGE_AW-1:0]   o_fail_stage;
    logic [STAGE_AW-1:0]   o_stage_addr;
    logic [ADDR_WIDTH-1:0] i_stage_nfeat;
    logic [ACC_WIDTH-1:0]  i_stage_thr;
    logic [ADDR_WIDTH-1:0] o_feat_addr;
    logic                  o_feat_issue;
    logic [DATA_WIDTH-1:0] i_haarvalue;

    modport master (
        input  i_start, i_stage_nfeat, i_stage_thr, i_haarvalue,
        output o_busy, o_done, o_face, o_fail_stage, o_stage_addr,
               o_feat_addr, o_feat_issue
    );

    modport slave (
        output i_start, i_stage_nfeat, i_stage_thr, i_haarvalue,
        input  o_busy, o_done, o_face, o_fail_stage, o_stage_addr,
               o_feat_addr, o_feat_issue
    );
endinterface
`default_nettype wire

// File: rtl/haar_valid_delay.sv
`default_nettype none
// ---------------------------------------------------------------------------
// haar_valid_delay : FEAT_LAT-deep valid shift register with drain flag
// Revision : 1.0
// ---------------------------------------------------------------------------
module haar_valid_delay #(
    parameter int FEAT_LAT = 5
) (
    input  wire logic clk,
    input  wire logic clear_n,
    input  wire logic in_valid,
    output logic      out_valid,
    output logic      pending
);
    logic [FEAT_LAT-1:0] r_sr;

    generate
        if (FEAT_LAT == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (!clear_n) r_sr <= '0;
                else          r_sr <= in_valid;
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (!clear_n) r_sr <= '0;
                else          r_sr <= {r_sr[FEAT_LAT-2:0], in_valid};
            end
        end
    endgenerate

    assign out_valid = r_sr[FEAT_LAT-1];
    // Excludes the emitting tap so the drain can end on the last accumulation edge.
    assign pending   = |(r_sr << 1);
endmodule
`default_nettype wire

// File: rtl/haar_stage_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// haar_stage_controller : runs one window through the Haar stage cascade
// Revision : 1.0
// ---------------------------------------------------------------------------
module haar_stage_controller
    import haar_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int STAGE_AW   = 4,
    parameter int NUM_STAGES = 10,
    parameter int FEAT_LAT   = 5,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
    input  wire logic clk,
    input  wire logic reset_n,
    haar_stage_controller_if.master bus
);
    localparam logic [STAGE_AW-1:0] c_last_stage = STAGE_AW'(NUM_STAGES - 1);

    state_t                       r_state;
    logic [STAGE_AW-1:0]          r_stage;
    logic [ADDR_WIDTH-1:0]        r_feat_addr;
    logic [ADDR_WIDTH-1:0]        r_cnt;
    logic signed [ACC_WIDTH-1:0]  r_thr;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_face;
    logic [STAGE_AW-1:0]          r_fail_stage;
    logic                         r_issue;

    logic                         w_valid;
    logic                         w_pending;
    logic                         w_pass;
    logic signed [ACC_WIDTH-1:0]  w_haar_ext;

    haar_valid_delay #(.FEAT_LAT(FEAT_LAT)) u_valid_delay (
        .clk       (clk),
        .clear_n   (reset_n),
        .in_valid  (r_issue),
        .out_valid (w_valid),
        .pending   (w_pending)
    );

    assign w_haar_ext = {{(ACC_WIDTH-DATA_WIDTH){bus.i_haarvalue[DATA_WIDTH-1]}}, bus.i_haarvalue};
    assign w_pass     = (r_acc >= r_thr);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_stage      <= '0;
            r_feat_addr  <= '0;
            r_cnt        <= '0;
            r_thr        <= '0;
            r_acc        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_face       <= 1'b0;
            r_fail_stage <= '0;
            r_issue      <= 1'b0;
        end else begin
            if (w_valid) r_acc <= r_acc + w_haar_ext;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        r_acc        <= '0;
                        r_stage      <= '0;
                        r_feat_addr  <= '0;
                        r_busy       <= 1'b1;
                        r_face       <= 1'b0;
                        r_fail_stage <= '0;
                        r_state      <= ST_STAGE_RD;
                    end
                end
                ST_STAGE_RD: r_state <= ST_STAGE_LAT;
                ST_STAGE_LAT: begin
                    r_thr <= bus.i_stage_thr;
                    r_cnt <= bus.i_stage_nfeat;
                    r_acc <= '0;
                    if (bus.i_stage_nfeat == '0) begin
                        r_state <= ST_EVAL;
                    end else begin
                        r_issue <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Feature address is never rewound between stages.
                    r_feat_addr <= r_feat_addr + ADDR_WIDTH'(1);
                    r_cnt       <= r_cnt - ADDR_WIDTH'(1);
                    if (r_cnt == ADDR_WIDTH'(1)) begin
                        r_issue <= 1'b0;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!w_pending) r_state <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (w_pass && (r_stage != c_last_stage)) begin
                        r_stage <= r_stage + STAGE_AW'(1);
                        r_state <= ST_STAGE_RD;
                    end else begin
                        r_face       <= w_pass;
                        r_fail_stage <= r_stage;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_busy       = r_busy;
    assign bus.o_done       = r_done;
    assign bus.o_face       = r_face;
    assign bus.o_fail_stage = r_fail_stage;
    assign bus.o_stage_addr = r_stage;
    assign bus.o_feat_addr  = r_feat_addr;
    assign bus.o_feat_issue = r_issue;
endmodule
`default_nettype wire

// File: tb/tb_haar_stage_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_haar_stage_controller : directed vector bench with ROM/classifier models
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_haar_stage_controller;
    localparam int NST = 3;

    typedef struct packed {
        logic [2:0][7:0]  nf;
        logic [2:0][7:0]  hv;
        logic [2:0][15:0] thr;
        logic             face;
        logic [3:0]       fail;
        logic [7:0]       lat;     // 0 = latency not checked
        logic [7:0]       issues;
        logic [3:0]       maxst;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  st_nf   [16];
    logic [15:0] st_thr  [16];
    logic [7:0]  feat_val[256];
    logic [4:0]  pv = '0;
    logic [7:0]  pa [5];
    vec_t        vt [7];

    haar_stage_controller_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .STAGE_AW(4)) bus ();

    haar_stage_controller #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .STAGE_AW(4), .NUM_STAGES(NST), .FEAT_LAT(5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stage ROM with one cycle read latency.
    always @(posedge clk) begin
        bus.i_stage_nfeat <= st_nf[bus.o_stage_addr];
        bus.i_stage_thr   <= st_thr[bus.o_stage_addr];
    end

    // Feature ROM + classifier: value for an issue in cycle c appears in cycle c+5.
    always @(posedge clk) begin
        pv    <= {pv[3:0], bus.o_feat_issue};
        pa[0] <= bus.o_feat_addr;
        for (int k = 1; k < 5; k++) pa[k] <= pa[k-1];
    end
    assign bus.i_haarvalue = pv[4] ? feat_val[pa[4]] : 8'h5A;

    function automatic vec_t mk(input int n0, n1, n2, h0, h1, h2, t0, t1, t2,
                                input int face, fail, lat, iss, mx);
        vec_t v;
        v.nf[0] = 8'(n0);   v.nf[1] = 8'(n1);   v.nf[2] = 8'(n2);
        v.hv[0] = 8'(h0);   v.hv[1] = 8'(h1);   v.hv[2] = 8'(h2);
        v.thr[0] = 16'(t0); v.thr[1] = 16'(t1); v.thr[2] = 16'(t2);
        v.face = 1'(face);  v.fail = 4'(fail);  v.lat = 8'(lat);
        v.issues = 8'(iss); v.maxst = 4'(mx);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        int a;
        a = 0;
        for (int s = 0; s < 16; s++) begin
            st_nf[s]  = '0;
            st_thr[s] = '0;
        end
        for (int s = 0; s < NST; s++) begin
            st_nf[s]  = v.nf[s];
            st_thr[s] = v.thr[s];
            for (int j = 0; j < int'(v.nf[s]); j++) begin
                feat_val[a[7:0]] = v.hv[s];
                a++;
            end
        end
    endtask

    // Start is held high through the whole run: it must be ignored while busy and in DONE.
    task automatic run(input vec_t v, input int id);
        int t0, lat, iss, aerr, mx;
        logic [7:0] eaddr;
        bit got;
        load(v);
        @(negedge clk);
        bus.i_start = 1'b1;
        t0 = cyc; iss = 0; aerr = 0; mx = 0; eaddr = '0; got = 0; lat = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 0) check($sformatf("v%0d_busy_after_start", id), 32'(bus.o_busy), 1);
            if (bus.o_feat_issue) begin
                if (bus.o_feat_addr !== eaddr) aerr++;
                eaddr = eaddr + 8'd1;
                iss++;
            end
            if (bus.o_busy && int'(bus.o_stage_addr) > mx) mx = int'(bus.o_stage_addr);
            if (bus.o_done) begin
                got = 1;
                lat = cyc - t0;
                break;
            end
        end
        bus.i_start = 1'b0;
        check($sformatf("v%0d_done_seen", id), 32'(got), 1);
        if (got) begin
            if (v.lat != 0) check($sformatf("v%0d_latency", id), 32'(lat), 32'(v.lat));
            check($sformatf("v%0d_face", id), 32'(bus.o_face), 32'(v.face));
            check($sformatf("v%0d_fail_stage", id), 32'(bus.o_fail_stage), 32'(v.fail));
            check($sformatf("v%0d_busy_at_done", id), 32'(bus.o_busy), 0);
            check($sformatf("v%0d_issue_count", id), 32'(iss), 32'(v.issues));
            check($sformatf("v%0d_addr_errors", id), 32'(aerr), 0);
            check($sformatf("v%0d_max_stage_addr", id), 32'(mx), 32'(v.maxst));
            @(negedge clk);
            check($sformatf("v%0d_done_one_cycle", id), 32'(bus.o_done), 0);
            check($sformatf("v%0d_idle_not_busy", id), 32'(bus.o_busy), 0);
            check($sformatf("v%0d_face_held", id), 32'(bus.o_face), 32'(v.face));
        end
    endtask

    initial begin
        int nd;
        bus.i_start = 1'b0;
        for (int i = 0; i < 256; i++) feat_val[i] = '0;
        //          nf        haar           thr            face fail lat iss max
        vt[0] = mk(3, 1, 1,   2,    0,  0,   6,    0, 0,    1,   2,  30, 5,  2);
        vt[1] = mk(3, 1, 1,   2,    0,  0,   7,    0, 0,    0,   0,  12, 3,  0);
        vt[2] = mk(2, 4, 1,   1,    1,  1,   2,    5, 0,    0,   1,  23, 6,  1);
        vt[3] = mk(0, 0, 0,   0,    0,  0,   0,    1, 0,    0,   1,  0,  0,  1);
        vt[4] = mk(2, 1, 1,   -128, 0,  0,   -256, 0, 0,    1,   2,  29, 4,  2);
        vt[5] = mk(2, 1, 1,   -128, 0,  0,   -255, 0, 0,    0,   0,  11, 2,  0);
        vt[6] = mk(1, 1, 1,   3,    3, -1,   3,    3, 0,    0,   2,  28, 3,  2);
        load(vt[0]);

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.o_busy), 0);
        check("rst_done", 32'(bus.o_done), 0);
        check("rst_face", 32'(bus.o_face), 0);
        check("rst_fail_stage", 32'(bus.o_fail_stage), 0);
        check("rst_feat_issue", 32'(bus.o_feat_issue), 0);
        check("rst_feat_addr", 32'(bus.o_feat_addr), 0);
        check("rst_stage_addr", 32'(bus.o_stage_addr), 0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 7; i++) run(vt[i], i);

        // Reset in DRAIN: values still in flight must not produce a verdict.
        load(vt[0]);
        @(negedge clk);
        bus.i_start = 1'b1;
        repeat (8) @(negedge clk);
        bus.i_start = 1'b0;
        check("mid_busy_before_reset", 32'(bus.o_busy), 1);
        check("mid_addr_before_reset", 32'(bus.o_feat_addr), 3);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(bus.o_busy), 0);
        check("mid_rst_feat_addr", 32'(bus.o_feat_addr), 0);
        check("mid_rst_feat_issue", 32'(bus.o_feat_issue), 0);
        reset_n = 1'b1;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) nd++;
        end
        check("no_activity_after_reset", 32'(nd), 0);
        run(vt[1], 10);
        run(vt[0], 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
